morse_capture: RTL and testbench

//  Receive side of the Morse path. Samples a debounced key input on a programmable tick.

---
 rtl/morse_capture_pkg.sv | 22 ++
 rtl/morse_tick.sv | 26 ++
 rtl/morse_capture.sv | 134 +++++++++++++
 tb/tb_morse_capture.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_capture_pkg.sv
// rtl/morse_capture_pkg.sv - shared Morse word constants and capture state encoding
package morse_capture_pkg;

  localparam int MORSE_W = 10;

  localparam logic [1:0] DOT_CODE  = 2'b10;
  localparam logic [2:0] DASH_CODE = 3'b110;
  localparam logic [3:0] DOT_LEN   = 4'd2;
  localparam logic [3:0] DASH_LEN  = 4'd3;

  // Symbol codes left-aligned in a word, ready to be shifted down to the write position.
  localparam logic [MORSE_W-1:0] DOT_MSB  = {DOT_CODE, {(MORSE_W - 2){1'b0}}};
  localparam logic [MORSE_W-1:0] DASH_MSB = {DASH_CODE, {(MORSE_W - 3){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/morse_tick.sv
// rtl/morse_tick.sv - programmable period counter, one tick every contador+1 cycles
module morse_tick #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] contador,
  output logic             tick
);

  logic [CNT_W-1:0] s;

  // Live compare: a new period is honoured once s wraps below it.
  assign tick = (s == contador);

  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
    end else if (tick) begin
      s <= '0;
    end else begin
      s <= s + CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_capture.sv
// rtl/morse_capture.sv - samples the key on ticks, classifies dot/dash runs and
// assembles the MSB-first morse word offered through a valid/ack handshake
module morse_capture
  import morse_capture_pkg::*;
#(
  parameter int CNT_W      = 25,
  parameter int DASH_TICKS = 2,
  parameter int END_TICKS  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic [CNT_W-1:0]   contador,
  input  logic               ack,
  output logic [MORSE_W-1:0] morse,
  output logic               valid,
  output logic               overflow,
  output logic               busy
);

  localparam int RUN_W = $clog2(DASH_TICKS + 1);
  localparam int GAP_W = $clog2(END_TICKS + 1);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(DASH_TICKS);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(END_TICKS);

  state_t             state, state_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [GAP_W-1:0]   gap, gap_n;
  logic [3:0]         bitcnt, bitcnt_n;
  logic [MORSE_W-1:0] buffer, buffer_n, morse_n;
  logic               valid_n, overflow_n;
  logic               tick;
  logic               is_dash, fits;
  logic [3:0]         sym_len;
  logic [MORSE_W-1:0] sym_bits;

  morse_tick #(.CNT_W(CNT_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .contador (contador),
    .tick     (tick)
  );

  // Bits below bitcnt are always zero, so OR-ing the shifted code is a write.
  assign is_dash  = (run >= RUN_SAT);
  assign sym_len  = is_dash ? DASH_LEN : DOT_LEN;
  assign sym_bits = (is_dash ? DASH_MSB : DOT_MSB) >> bitcnt;
  assign fits     = ({1'b0, bitcnt} + {1'b0, sym_len}) <= 5'(MORSE_W);
  assign busy     = (state == S_MARK) || (state == S_SPACE);

  always_comb begin
    state_n    = state;
    run_n      = run;
    gap_n      = gap;
    bitcnt_n   = bitcnt;
    buffer_n   = buffer;
    morse_n    = morse;
    valid_n    = valid;
    overflow_n = overflow;
    case (state)
      S_IDLE: begin
        if (tick && key) begin
          state_n    = S_MARK;
          run_n      = RUN_W'(1);
          buffer_n   = '0;
          bitcnt_n   = '0;
          overflow_n = 1'b0;
        end
      end
      S_MARK: begin
        if (tick) begin
          if (key) begin
            if (run < RUN_SAT) run_n = run + RUN_W'(1);
          end else begin
            if (fits) begin
              buffer_n = buffer | sym_bits;
              bitcnt_n = bitcnt + sym_len;
            end else begin
              overflow_n = 1'b1;
            end
            gap_n   = GAP_W'(1);
            state_n = S_SPACE;
          end
        end
      end
      S_SPACE: begin
        if (tick) begin
          if (key) begin
            state_n = S_MARK;
            run_n   = RUN_W'(1);
          end else begin
            gap_n = gap + GAP_W'(1);
            if (gap_n == GAP_END) begin
              morse_n = buffer;
              valid_n = 1'b1;
              state_n = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        // ack takes priority over any tick; the key is not looked at here.
        if (ack) begin
          valid_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      run      <= '0;
      gap      <= '0;
      bitcnt   <= '0;
      buffer   <= '0;
      morse    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      run      <= run_n;
      gap      <= gap_n;
      bitcnt   <= bitcnt_n;
      buffer   <= buffer_n;
      morse    <= morse_n;
      valid    <= valid_n;
      overflow <= overflow_n;
    end
  end

endmodule

// File: tb/tb_morse_capture.sv
// tb/tb_morse_capture.sv - vector table, hand sequences and randomized key traffic
// checked against a symbol-list reference model
module tb_morse_capture;

  localparam int DASH_T = 2;
  localparam int END_T  = 3;
  localparam int WORD_W = 10;

  localparam logic [9:0] W_DOT   = 10'b1000000000;
  localparam logic [9:0] W_DD    = 10'b1101000000;
  localparam logic [9:0] W_4DASH = 10'b1101101100;
  localparam logic [9:0] W_DASH  = 10'b1100000000;

  logic        clk = 1'b0;
  logic        reset, key, ack;
  logic [24:0] contador;
  logic [9:0]  morse;
  logic        valid, overflow, busy;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

  morse_capture dut (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .contador (contador),
    .ack      (ack),
    .morse    (morse),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: keeps the accepted symbols as a list and builds the word from it.
  int  m_mode;
  int  m_run, m_gap, m_used, m_k;
  bit  m_syms[$];
  logic       e_valid, e_ovf;
  logic [9:0] e_morse;

  function automatic logic [9:0] build_word();
    logic [9:0] w = '0;
    int pos = WORD_W - 1;
    foreach (m_syms[i]) begin
      w[pos] = 1'b1;
      if (m_syms[i]) begin
        w[pos-1] = 1'b1;
        pos -= 3;
      end else begin
        pos -= 2;
      end
    end
    return w;
  endfunction

  function automatic void model_edge(input logic k, input logic a, input logic r);
    bit tk;
    int len;
    if (r) begin
      m_mode = 0; m_syms.delete(); m_used = 0; m_k = 0;
      e_valid = 0; e_ovf = 0; e_morse = '0;
      return;
    end
    tk = ((m_k % (cnt + 1)) == cnt);
    m_k++;
    if (m_mode == 3) begin
      if (a) begin m_mode = 0; e_valid = 0; end
    end else if (tk) begin
      if (m_mode == 0) begin
        if (k) begin m_mode = 1; m_run = 1; m_syms.delete(); m_used = 0; e_ovf = 0; end
      end else if (m_mode == 1) begin
        if (k) m_run++;
        else begin
          len = (m_run >= DASH_T) ? 3 : 2;
          if (m_used + len <= WORD_W) begin
            m_syms.push_back(m_run >= DASH_T);
            m_used += len;
          end else e_ovf = 1;
          m_gap = 1; m_mode = 2;
        end
      end else begin
        if (k) begin m_mode = 1; m_run = 1; end
        else begin
          m_gap++;
          if (m_gap >= END_T) begin e_morse = build_word(); e_valid = 1; m_mode = 3; end
        end
      end
    end
  endfunction

  task automatic step(input logic k, input logic a, input logic r);
    key = k; ack = a; reset = r;
    contador = 25'(cnt);
    @(posedge clk);
    model_edge(k, a, r);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic       k, a, r;
    logic       v;
    logic [9:0] m;
    logic       o, b;
  } vec_t;
  vec_t tv[$];

  function automatic void add(input logic k, a, r, v, input logic [9:0] m, input logic o, b);
    vec_t e;
    e.k = k; e.a = a; e.r = r; e.v = v; e.m = m; e.o = o; e.b = b;
    tv.push_back(e);
  endfunction

  initial begin
    key = 0; ack = 0; reset = 1; contador = '0;

    // Directed table, one tick per cycle.
    cnt = 0;
    add(0,0,1, 0,'0,0,0);
    add(1,0,0, 0,'0,0,1);
    add(0,0,0, 0,'0,0,1);
    add(0,0,0, 0,'0,0,1);
    add(0,0,0, 1,W_DOT,0,0);
    add(1,1,0, 0,W_DOT,0,0);
    add(0,0,0, 0,W_DOT,0,0);
    add(1,0,0, 0,W_DOT,0,1);
    add(1,0,0, 0,W_DOT,0,1);
    add(0,0,0, 0,W_DOT,0,1);
    add(1,0,0, 0,W_DOT,0,1);
    add(0,0,0, 0,W_DOT,0,1);
    add(0,0,0, 0,W_DOT,0,1);
    add(0,0,0, 1,W_DD,0,0);
    for (int i = 0; i < 20; i++) add(logic'(i % 2 == 0), 0,0, 1,W_DD,0,0);
    add(1,1,0, 0,W_DD,0,0);
    add(0,0,0, 0,W_DD,0,0);
    for (int d = 0; d < 4; d++) begin
      add(1,0,0, 0,W_DD,0,1);
      add(1,0,0, 0,W_DD,0,1);
      add(0,0,0, 0,W_DD,logic'(d == 3),1);
    end
    add(0,0,0, 0,W_DD,1,1);
    add(0,0,0, 1,W_4DASH,1,0);
    add(0,1,0, 0,W_4DASH,1,0);
    add(1,0,0, 0,W_4DASH,0,1);
    add(1,0,1, 0,'0,0,0);
    add(1,0,0, 0,'0,0,1);
    add(0,0,0, 0,'0,0,1);
    add(0,0,0, 0,'0,0,1);
    add(0,0,0, 1,W_DOT,0,0);
    add(0,1,0, 0,W_DOT,0,0);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].k, tv[i].a, tv[i].r);
      check("valid", i, 32'(valid), 32'(tv[i].v));
      check("morse", i, 32'(morse), 32'(tv[i].m));
      check("overflow", i, 32'(overflow), 32'(tv[i].o));
      check("busy", i, 32'(busy), 32'(tv[i].b));
    end

    // contador=4: short pulse between ticks is ignored, held key makes a dash.
    cnt = 4;
    step(0,0,1);
    for (int k = 0; k < 30; k++) begin
      step(logic'((k >= 1 && k <= 2) || (k >= 9 && k <= 14)), 0, 0);
      if (k == 8)  check("slow_idle", k, 32'(busy), 32'd0);
      if (k == 9)  check("slow_mark", k, 32'(busy), 32'd1);
      if (k == 19) check("slow_space", k, 32'(busy), 32'd1);
      if (k == 28) check("slow_novalid", k, 32'(valid), 32'd0);
    end
    check("slow_valid", 29, 32'(valid), 32'd1);
    check("slow_morse", 29, 32'(morse), 32'(W_DASH));
    step(0,1,0);
    check("slow_ack", 30, 32'(valid), 32'd0);

    // Randomized key traffic against the reference model.
    for (int run = 0; run < 8; run++) begin
      logic k;
      cnt = int'($urandom_range(0, 2));
      step(0,0,1);
      k = 0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 5) == 0) k = ~k;
        step(k, logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 499) == 0));
        check("rnd_valid", c, 32'(valid), 32'(e_valid));
        check("rnd_morse", c, 32'(morse), 32'(e_morse));
        check("rnd_overflow", c, 32'(overflow), 32'(e_ovf));
        check("rnd_busy", c, 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
